// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

    // Receiver FSM states; IDLE is the only non-busy state.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

    // Frame format is 8N1; the datapath width is tied to this value.
    localparam int DATA_BITS = 8;

    // Level the serial line rests at between frames.
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous inputs.
// Latency: 2 clk cycles from d to q.
// Backpressure: none (free-running level path).
//
// Ports:
//   clk      - destination clock, rising edge
//   reset_n  - asynchronous active-low reset; both flops load RST_VAL
//   d        - asynchronous input
//   q        - synchronized output
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples rx, recovers bytes LSB-first, flags bad stop bits.
// Latency: data_valid about 3 + H + 9*CLKS_PER_BIT cycles after rx falls, H = (CLKS_PER_BIT-1)/2.
// Backpressure: none; uart_data is held until the next good byte, pulses are single-cycle.
//
// Ports:
//   clk         - system clock, rising edge
//   reset_n     - asynchronous active-low reset
//   rx          - raw serial line, asynchronous, idle high
//   uart_data   - last correctly framed byte, held until replaced
//   data_valid  - one-cycle pulse when uart_data is updated
//   frame_error - one-cycle pulse when the stop bit samples low
//   busy        - high whenever the FSM is outside IDLE
//
// CLKS_PER_BIT must be >= 4 so the half-bit point and bit counter are meaningful.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] uart_data,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_state_t       state,      state_nxt;
    logic [CNT_W-1:0]     clk_cnt,    clk_cnt_nxt;
    logic [IDX_W-1:0]     bit_idx,    bit_idx_nxt;
    logic [DATA_BITS-1:0] shift,      shift_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 valid_nxt;
    logic                 ferr_nxt;

    // Flops reset to the idle level so a reset release never looks like a start edge.
    sync_2ff #(
        .RST_VAL (UART_IDLE_LEVEL)
    ) u_rx_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        data_nxt    = uart_data;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;

        case (state)
            IDLE: begin
                clk_cnt_nxt = '0;
                bit_idx_nxt = '0;
                if (rx_s != UART_IDLE_LEVEL) begin
                    state_nxt = START;
                end
            end

            START: begin
                // Re-check the line mid start bit; a short low pulse is a glitch.
                if (clk_cnt == HALF_CNT) begin
                    clk_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = (rx_s == UART_IDLE_LEVEL) ? IDLE : DATA;
                end else begin
                    clk_cnt_nxt = clk_cnt + CNT_W'(1);
                end
            end

            DATA: begin
                // Counter is already phase-aligned to bit centres by START.
                if (clk_cnt == LAST_CNT) begin
                    clk_cnt_nxt        = '0;
                    shift_nxt[bit_idx] = rx_s;
                    if (bit_idx == LAST_IDX) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + CNT_W'(1);
                end
            end

            STOP: begin
                // Leaving at the stop-bit centre leaves half a bit of slack for the next start edge.
                if (clk_cnt == LAST_CNT) begin
                    clk_cnt_nxt = '0;
                    if (rx_s == UART_IDLE_LEVEL) begin
                        data_nxt  = shift;
                        valid_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + CNT_W'(1);
                end
            end

            WAIT_IDLE: begin
                // A held-low line (break) must not be read as a stream of new frames.
                clk_cnt_nxt = '0;
                if (rx_s == UART_IDLE_LEVEL) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt   = IDLE;
                clk_cnt_nxt = '0;
                bit_idx_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            uart_data   <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            clk_cnt     <= clk_cnt_nxt;
            bit_idx     <= bit_idx_nxt;
            shift       <= shift_nxt;
            uart_data   <= data_nxt;
            data_valid  <= valid_nxt;
            frame_error <= ferr_nxt;
            busy        <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT=16 (dut_a) and 5 (dut_b).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx;

    localparam int CPB_A = 16;
    localparam int CPB_B = 5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx;
    logic [7:0] ud_a, ud_b;
    logic       dv_a, dv_b, fe_a, fe_b, busy_a, busy_b;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB_A)) dut_a (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx          (rx),
        .uart_data   (ud_a),
        .data_valid  (dv_a),
        .frame_error (fe_a),
        .busy        (busy_a)
    );

    uart_rx #(.CLKS_PER_BIT(CPB_B)) dut_b (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx          (rx),
        .uart_data   (ud_b),
        .data_valid  (dv_b),
        .frame_error (fe_b),
        .busy        (busy_b)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    // Output monitors: every pulse seen on the falling edge is logged.
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    int         dv_cyc_a[$];
    int         dv_cnt_a = 0, fe_cnt_a = 0, dv_cnt_b = 0, fe_cnt_b = 0;
    int         mutex_err = 0;

    always @(negedge clk) begin
        if (dv_a) begin
            got_a.push_back(ud_a);
            dv_cyc_a.push_back(cyc);
            dv_cnt_a++;
        end
        if (fe_a) fe_cnt_a++;
        if (dv_b) begin
            got_b.push_back(ud_b);
            dv_cnt_b++;
        end
        if (fe_b) fe_cnt_b++;
        if ((dv_a && fe_a) || (dv_b && fe_b)) mutex_err++;
    end

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_range(input string nm, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // All stimulus changes land 1 time unit after a rising edge.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v, input int cpb);
        rx = v;
        wait_cyc(cpb);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int cpb);
        send_bit(1'b0, cpb);
        for (int i = 0; i < 8; i++) send_bit(d[i], cpb);
        send_bit(stop, cpb);
    endtask

    function automatic logic [7:0] got_at(input bit sel_b, input int idx);
        return sel_b ? got_b[idx] : got_a[idx];
    endfunction

    // Reference model: a good stop bit queues the byte, a bad one counts an error.
    task automatic run_random(input bit sel_b, input int cpb, input int n);
        logic [7:0] exp_q[$];
        int         exp_fe = 0;
        int         base_got = sel_b ? got_b.size() : got_a.size();
        int         base_fe  = sel_b ? fe_cnt_b : fe_cnt_a;
        int         ngot;
        logic [7:0] d;
        logic       stop;
        for (int k = 0; k < n; k++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, stop, cpb);
            rx = 1'b1;
            if (stop) begin
                exp_q.push_back(d);
                wait_cyc($urandom_range(0, 2 * cpb));
            end else begin
                exp_fe++;
                wait_cyc(cpb + $urandom_range(0, cpb));
            end
        end
        wait_cyc(2 * cpb);
        ngot = (sel_b ? got_b.size() : got_a.size()) - base_got;
        check(sel_b ? "rand_b_count" : "rand_a_count", ngot, exp_q.size());
        check(sel_b ? "rand_b_ferr" : "rand_a_ferr",
              (sel_b ? fe_cnt_b : fe_cnt_a) - base_fe, exp_fe);
        for (int i = 0; i < exp_q.size() && i < ngot; i++)
            check(sel_b ? "rand_b_byte" : "rand_a_byte", got_at(sel_b, base_got + i), exp_q[i]);
    endtask

    // Abort a frame during data bit 3, then prove a clean frame is received.
    task automatic reset_mid(input bit sel_b, input int cpb);
        logic [7:0] part = 8'hC3;
        int         base_dv, base_fe, base_got;
        send_bit(1'b0, cpb);
        for (int i = 0; i < 3; i++) send_bit(part[i], cpb);
        rx = part[3];
        wait_cyc(cpb / 2);
        reset_n = 1'b0;
        #1;
        check(sel_b ? "rst_mid_b_data" : "rst_mid_a_data", sel_b ? ud_b : ud_a, 8'h00);
        check(sel_b ? "rst_mid_b_busy" : "rst_mid_a_busy", sel_b ? busy_b : busy_a, 0);
        check(sel_b ? "rst_mid_b_dv" : "rst_mid_a_dv", sel_b ? dv_b : dv_a, 0);
        rx = 1'b1;
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(3);
        base_dv  = sel_b ? dv_cnt_b : dv_cnt_a;
        base_fe  = sel_b ? fe_cnt_b : fe_cnt_a;
        base_got = sel_b ? got_b.size() : got_a.size();
        send_frame(8'h5A, 1'b1, cpb);
        rx = 1'b1;
        wait_cyc(2 * cpb);
        check(sel_b ? "rst_mid_b_nvalid" : "rst_mid_a_nvalid",
              (sel_b ? dv_cnt_b : dv_cnt_a) - base_dv, 1);
        check(sel_b ? "rst_mid_b_nferr" : "rst_mid_a_nferr",
              (sel_b ? fe_cnt_b : fe_cnt_a) - base_fe, 0);
        if ((sel_b ? got_b.size() : got_a.size()) > base_got)
            check(sel_b ? "rst_mid_b_byte" : "rst_mid_a_byte", got_at(sel_b, base_got), 8'h5A);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int         viol;
        int         b_dv, b_fe, b_got, t0;
        logic [7:0] last_good;

        vecs[0] = '{8'hA5, 1'b1, 1, 0};
        vecs[1] = '{8'h3C, 1'b0, 0, 1};
        vecs[2] = '{8'h00, 1'b1, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, 1, 0};
        vecs[4] = '{8'h81, 1'b0, 0, 1};
        vecs[5] = '{8'h5A, 1'b1, 1, 0};
        vecs[6] = '{8'h7E, 1'b1, 1, 0};

        // Reset with the line idle, then confirm 100 quiet cycles on both instances.
        rx      = 1'b1;
        reset_n = 1'b0;
        #1;
        check("rst_data_a", ud_a, 8'h00);
        check("rst_busy_a", busy_a, 0);
        wait_cyc(4);
        reset_n = 1'b1;
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (dv_a || fe_a || busy_a || ud_a != 8'h00 ||
                dv_b || fe_b || busy_b || ud_b != 8'h00) viol++;
        end
        check("idle_quiet", viol, 0);
        wait_cyc(1);

        // Table-driven frames on the 16x instance.
        last_good = 8'h00;
        for (int v = 0; v < 7; v++) begin
            b_dv = dv_cnt_a;
            b_fe = fe_cnt_a;
            send_frame(vecs[v].data, vecs[v].stop, CPB_A);
            rx = 1'b1;
            wait_cyc(2 * CPB_A);
            if (vecs[v].stop) last_good = vecs[v].data;
            check("vec_nvalid", dv_cnt_a - b_dv, vecs[v].exp_valid);
            check("vec_nferr", fe_cnt_a - b_fe, vecs[v].exp_ferr);
            check("vec_data", ud_a, last_good);
            check("vec_busy_idle", busy_a, 0);
        end

        // Back-to-back 0x00 then 0xFF with no idle gap; also measures first-byte latency.
        b_got = got_a.size();
        t0    = cyc + 1;
        send_frame(8'h00, 1'b1, CPB_A);
        send_frame(8'hFF, 1'b1, CPB_A);
        rx = 1'b1;
        wait_cyc(2 * CPB_A);
        check("b2b_count", got_a.size() - b_got, 2);
        if (got_a.size() - b_got == 2) begin
            check("b2b_first", got_a[b_got], 8'h00);
            check("b2b_second", got_a[b_got + 1], 8'hFF);
            check_range("b2b_interval", dv_cyc_a[b_got + 1] - dv_cyc_a[b_got],
                        10 * CPB_A - 1, 10 * CPB_A + 1);
            check_range("latency", dv_cyc_a[b_got] - t0,
                        2 + (CPB_A - 1) / 2 + 9 * CPB_A,
                        2 + (CPB_A - 1) / 2 + 9 * CPB_A + 2);
        end

        // Break: good 0xA5, then 0x3C with a low stop bit and the line held low.
        send_frame(8'hA5, 1'b1, CPB_A);
        rx = 1'b1;
        wait_cyc(CPB_A);
        b_dv = dv_cnt_a;
        b_fe = fe_cnt_a;
        send_frame(8'h3C, 1'b0, CPB_A);
        wait_cyc(64);
        check("break_busy_low", busy_a, 1);
        check("break_nferr", fe_cnt_a - b_fe, 1);
        check("break_nvalid", dv_cnt_a - b_dv, 0);
        check("break_data", ud_a, 8'hA5);
        rx = 1'b1;
        wait_cyc(1);
        check("break_busy_sync", busy_a, 1);
        wait_cyc(4);
        check("break_busy_release", busy_a, 0);
        wait_cyc(2 * CPB_A);
        check("break_no_retrigger", dv_cnt_a - b_dv + fe_cnt_a - b_fe, 1);

        // Short low glitch shorter than half a bit.
        b_dv = dv_cnt_a;
        b_fe = fe_cnt_a;
        rx   = 1'b0;
        wait_cyc(4);
        rx = 1'b1;
        wait_cyc(2);
        check("glitch_busy_mid", busy_a, 1);
        wait_cyc(8);
        check("glitch_busy_end", busy_a, 0);
        wait_cyc(3 * CPB_A);
        check("glitch_nvalid", dv_cnt_a - b_dv, 0);
        check("glitch_nferr", fe_cnt_a - b_fe, 0);

        reset_mid(1'b0, CPB_A);
        run_random(1'b0, CPB_A, 12);

        // Odd divisor instance: fresh reset so earlier 16x traffic is forgotten.
        reset_n = 1'b0;
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(3);
        run_random(1'b1, CPB_B, 16);
        reset_mid(1'b1, CPB_B);

        check("dv_fe_mutex", mutex_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
